// File: rtl/serial_tc_decoder_if.sv
// Bundle of the serial receive link and the decoded parallel result.
//   i, start                        : serial bit stream and frame marker (driven by the master)
//   dout, dout_valid, ovf,
//   frame_err, busy                 : decoded word and status (driven by the decoder)
// The slave modport is the decoder's view; the master modport is the upstream/consumer view.
interface serial_tc_decoder_if #(
  parameter int unsigned W = 8
);
  logic         i;
  logic         start;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         ovf;
  logic         frame_err;
  logic         busy;

  modport slave (
    input  i,
    input  start,
    output dout,
    output dout_valid,
    output ovf,
    output frame_err,
    output busy
  );

  modport master (
    output i,
    output start,
    input  dout,
    input  dout_valid,
    input  ovf,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/serial_tc_decoder.sv
// Bit-serial two's-complement decoder (receive side).
// Collects an LSB-first frame of W bits, passing bits through up to and including the first '1'
// and inverting every later bit, then presents the word in parallel with a one-cycle strobe.
// Ports:
//   clk : system clock, rising edge
//   r   : synchronous active-high reset
//   bus : slave view of serial_tc_decoder_if (i, start in; dout, dout_valid, ovf, frame_err,
//         busy out)
module serial_tc_decoder #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = $clog2(W)
) (
  input  logic                 clk,
  input  logic                 r,
  serial_tc_decoder_if.slave   bus
);

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          seen_q, seen_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          ferr_q, ferr_d;
  logic          dk;

  // Once a '1' has passed, every following bit is inverted.
  assign dk = seen_q ? ~bus.i : bus.i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    sr_d    = sr_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ovf_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          sr_d    = '0;
          sr_d[0] = bus.i;
          seen_d  = bus.i;
          cnt_d   = CW'(1);
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (bus.start) begin
          // Restart: current bit becomes bit 0 of a fresh frame.
          ferr_d  = 1'b1;
          sr_d    = '0;
          sr_d[0] = bus.i;
          seen_d  = bus.i;
          cnt_d   = CW'(1);
        end else begin
          sr_d[cnt_q] = dk;
          seen_d      = seen_q | bus.i;
          cnt_d       = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            dout_d  = sr_d;
            valid_d = 1'b1;
            // Only a raw 1 followed by zeros leaves the low bits zero with a final '1'.
            ovf_d   = (sr_q[W-2:0] == '0) && dk;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      sr_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.ovf        = ovf_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q == StRecv);

endmodule

// File: tb/tb_serial_tc_decoder.sv
module tb_serial_tc_decoder;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic r   = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   n_strobe = 0;
  int   strobe_cyc[$];

  serial_tc_decoder_if #(.W(W)) bus ();

  serial_tc_decoder #(.W(W)) dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: gathers the raw frame as an integer and negates it arithmetically.
  logic [7:0] m_dout  = '0;
  logic       m_valid = 1'b0;
  logic       m_ovf   = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_busy  = 1'b0;
  int         m_n     = 0;
  int         m_raw   = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (r) begin
      m_dout = '0; m_valid = 0; m_ovf = 0; m_ferr = 0; m_busy = 0; m_n = 0; m_raw = 0;
    end else begin
      m_valid = 0; m_ovf = 0; m_ferr = 0;
      if (bus.start) begin
        m_ferr = m_busy;
        m_raw  = int'(bus.i);
        m_n    = 1;
        m_busy = 1;
      end else if (m_busy) begin
        m_raw = m_raw + (int'(bus.i) << m_n);
        m_n   = m_n + 1;
        if (m_n == W) begin
          m_dout  = 8'((256 - m_raw) % 256);
          m_valid = 1;
          m_ovf   = (m_raw == 128);
          m_busy  = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("cyc_dout_valid", 32'(bus.dout_valid), 32'(m_valid));
      check("cyc_dout", 32'(bus.dout), 32'(m_dout));
      check("cyc_ovf", 32'(bus.ovf), 32'(m_ovf));
      check("cyc_frame_err", 32'(bus.frame_err), 32'(m_ferr));
      check("cyc_busy", 32'(bus.busy), 32'(m_busy));
      if (bus.dout_valid === 1'b1) begin
        n_strobe++;
        strobe_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive bits [from..to] of raw; start accompanies bit 0.
  task automatic send_bits(input logic [7:0] raw, input int from, input int to);
    for (int b = from; b <= to; b++) begin
      bus.start = (b == 0);
      bus.i     = raw[b];
      tick();
    end
    bus.start = 1'b0;
    bus.i     = 1'b0;
  endtask

  task automatic check_word(input string name, input logic [7:0] d, input logic o);
    check({name, "_valid"}, 32'(bus.dout_valid), 32'd1);
    check({name, "_dout"}, 32'(bus.dout), 32'(d));
    check({name, "_ovf"}, 32'(bus.ovf), 32'(o));
  endtask

  initial begin
    int s0;
    logic [7:0] v8;
    bus.start = 1'b0;
    bus.i     = 1'b0;
    r         = 1'b1;
    tick();
    tick();
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ferr", 32'(bus.frame_err), 32'd0);
    r = 1'b0;
    tick();

    // Basic frame 0xFB -> 0x05.
    send_bits(8'hFB, 0, 7);
    check_word("fb", 8'h05, 1'b0);
    tick();
    check("fb_busy_after", 32'(bus.busy), 32'd0);
    check("fb_valid_drop", 32'(bus.dout_valid), 32'd0);
    check("fb_dout_hold", 32'(bus.dout), 32'h05);

    send_bits(8'h80, 0, 7); check_word("x80", 8'h80, 1'b1); tick();
    send_bits(8'h00, 0, 7); check_word("x00", 8'h00, 1'b0); tick();
    send_bits(8'h01, 0, 7); check_word("x01", 8'hFF, 1'b0); tick();

    // Back-to-back: second start lands in the strobe cycle.
    s0 = strobe_cyc.size();
    send_bits(8'h03, 0, 7); check_word("b2b_a", 8'hFD, 1'b0);
    send_bits(8'hFE, 0, 7); check_word("b2b_b", 8'h02, 1'b0);
    tick();
    check("b2b_strobes", 32'(strobe_cyc.size() - s0), 32'd2);
    if (strobe_cyc.size() - s0 == 2)
      check("b2b_spacing", 32'(strobe_cyc[s0+1] - strobe_cyc[s0]), 32'd8);

    // Abort at bit 4 with a new frame 0x10.
    s0 = n_strobe;
    send_bits(8'hAA, 0, 3);
    send_bits(8'h10, 0, 0);
    check("abort_ferr", 32'(bus.frame_err), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd1);
    send_bits(8'h10, 1, 7);
    check_word("abort_new", 8'hF0, 1'b0);
    tick();
    check("abort_strobes", 32'(n_strobe - s0), 32'd1);

    // Reset at bit 5.
    s0 = n_strobe;
    send_bits(8'hAA, 0, 4);
    r = 1'b1;
    tick();
    r = 1'b0;
    check("rmid_dout", 32'(bus.dout), 32'd0);
    check("rmid_busy", 32'(bus.busy), 32'd0);
    check("rmid_ferr", 32'(bus.frame_err), 32'd0);
    for (int k = 0; k < 4; k++) tick();
    check("rmid_no_strobe", 32'(n_strobe - s0), 32'd0);
    send_bits(8'h7F, 0, 7); check_word("x7f", 8'h81, 1'b0); tick();

    // Reset beats start.
    r = 1'b1; bus.start = 1'b1; bus.i = 1'b1;
    tick();
    r = 1'b0; bus.start = 1'b0; bus.i = 1'b0;
    check("rst_start_busy", 32'(bus.busy), 32'd0);
    tick();
    check("rst_start_busy2", 32'(bus.busy), 32'd0);

    // Full sweep, back-to-back.
    for (int v = 0; v < 256; v++) begin
      v8 = 8'(v);
      send_bits(v8, 0, 7);
      check_word("sweep", 8'(256 - v), (v == 128));
    end
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
